// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// dff -- parameterised multi-bit D register with asynchronous clear and
// asynchronous preset.
//
// Generic storage primitive for any registered vector that must be forced
// into a known state. There is a single clock domain and no combinational
// path from d_i to q_o.
//
// Parameters
//   WIDTH    number of register bits (1..1024)
//   RST_VAL  value held while rst_i is low (truncated/zero-extended to WIDTH)
//   SET_VAL  value held while set_i is high and rst_i is high
//
// Ports
//   clk_i   in   1      rising-edge clock
//   rst_i   in   1      asynchronous reset, active-low, highest priority
//   set_i   in   1      asynchronous preset, active-high
//   clr_i   in   1      synchronous clear, active-high (DFF_SYNC_CLR_EN only)
//   d_i     in   WIDTH  data input
//   q_o     out  WIDTH  registered output
//
// Optional feature macro: DFF_SYNC_CLR_EN
//   When defined, adds clr_i. On a rising clock edge with no asynchronous
//   force active, clr_i=1 loads RST_VAL instead of d_i.
// ---------------------------------------------------------------------------
module dff #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
`ifdef DFF_SYNC_CLR_EN
    input  logic             clr_i,
`endif
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Asynchronous force state shared by all bits.
    logic rst_force;
    logic set_force;

    assign rst_force = ~rst_i;
    assign set_force = rst_i & set_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Each bit is an independent flop with an asynchronous clear line and
        // an asynchronous preset line. The lines are derived from the target
        // value the bit must be forced to, so releasing rst_i while set_i is
        // still high produces a fresh edge on whichever line now applies and
        // the bit moves to SET_VAL at once instead of waiting for a clock.
        // The two lines are mutually exclusive by construction.
        logic bit_clr;
        logic bit_pre;
        logic bit_q;

        assign bit_clr = (rst_force & ~RST_VAL[i]) | (set_force & ~SET_VAL[i]);
        assign bit_pre = (rst_force &  RST_VAL[i]) | (set_force &  SET_VAL[i]);

        always_ff @(posedge clk_i or posedge bit_clr or posedge bit_pre) begin
            if (bit_clr) begin
                bit_q <= 1'b0;
            end else if (bit_pre) begin
                bit_q <= 1'b1;
            end else begin
`ifdef DFF_SYNC_CLR_EN
                bit_q <= clr_i ? RST_VAL[i] : d_i[i];
`else
                bit_q <= d_i[i];
`endif
            end
        end

        assign q_o[i] = bit_q;
    end

endmodule

// File: tb/tb_dff.sv
// ---------------------------------------------------------------------------
// tb_dff -- directed self-checking bench for dff (WIDTH=8, default reset and
// preset values). Define DFF_SYNC_CLR_EN to also exercise the synchronous
// clear. Clock period 10, rising edges at 5, 15, 25, ...
// ---------------------------------------------------------------------------
module tb_dff;

    logic       clk_i;
    logic       rst_i;
    logic       set_i;
    logic [7:0] d_i;
    logic [7:0] q_o;
`ifdef DFF_SYNC_CLR_EN
    logic       clr_i;
`endif

    int checks = 0;
    int errors = 0;

    dff #(.WIDTH(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .set_i (set_i),
`ifdef DFF_SYNC_CLR_EN
        .clr_i (clr_i),
`endif
        .d_i   (d_i),
        .q_o   (q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] expected);
        checks++;
        assert (q_o === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, q_o, expected);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        set_i = 1'b0;
        d_i   = 8'h00;
`ifdef DFF_SYNC_CLR_EN
        clr_i = 1'b0;
`endif

        // Asynchronous reset mid-cycle, no clock edge involved.
        #13 rst_i = 1'b0;
        #1  check("reset_async", 8'h00);

        // Reset held across a clock edge with nonzero data.
        d_i = 8'hAA;
        @(posedge clk_i); #1;
        check("reset_hold_clk", 8'h00);

        // Releasing reset does not load data before a clock edge.
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #1 check("reset_release_hold", 8'h00);

        // Asynchronous preset mid-cycle.
        #1 set_i = 1'b1;
        #1 check("set_async", 8'hFF);

        // Preset held across a clock edge.
        @(posedge clk_i); #1;
        check("set_hold_clk", 8'hFF);

        // Reset and preset together: reset wins.
        rst_i = 1'b0;
        #1 check("rst_and_set", 8'h00);

        // Release reset while preset still high: preset value at once.
        rst_i = 1'b1;
        #1 check("rst_release_set_high", 8'hFF);

        // Release preset: value held until the next rising edge.
        @(negedge clk_i);
        set_i = 1'b0;
        d_i   = 8'hAA;
        #1 check("set_release_hold", 8'hFF);
        @(posedge clk_i); #1;
        check("load_aa", 8'hAA);

        // Feed back the inverted output.
        @(negedge clk_i);
        d_i = ~q_o;
        @(posedge clk_i); #1;
        check("load_inverted", 8'h55);

        // Data changes between edges are ignored.
        @(negedge clk_i);
        d_i = 8'h3C;
        #2 check("midcycle_ignore_a", 8'h55);
        d_i = 8'hC3;
        #2 check("midcycle_ignore_b", 8'h55);
        @(posedge clk_i); #1;
        check("load_c3", 8'hC3);

        // A few distinct data patterns, one-cycle latency each.
        @(negedge clk_i); d_i = 8'h01;
        @(posedge clk_i); #1; check("load_01", 8'h01);
        @(negedge clk_i); d_i = 8'h80;
        @(posedge clk_i); #1; check("load_80", 8'h80);
        @(negedge clk_i); d_i = 8'hFF;
        @(posedge clk_i); #1; check("load_ff", 8'hFF);
        @(negedge clk_i); d_i = 8'h00;
        @(posedge clk_i); #1; check("load_00", 8'h00);

        // Asynchronous reset from a nonzero data state, then recover.
        @(negedge clk_i); d_i = 8'h5A;
        @(posedge clk_i); #1; check("load_5a", 8'h5A);
        #2 rst_i = 1'b0;
        #1 check("reset_from_data", 8'h00);
        rst_i = 1'b1;
        @(posedge clk_i); #1; check("reload_after_reset", 8'h5A);

        // Asynchronous preset from a data state, without a clock.
        @(negedge clk_i);
        set_i = 1'b1;
        #1 check("set_from_data", 8'hFF);
        set_i = 1'b0;
        d_i   = 8'h12;
        @(posedge clk_i); #1; check("reload_after_set", 8'h12);

`ifdef DFF_SYNC_CLR_EN
        // Synchronous clear overrides data at the clock edge.
        @(negedge clk_i); d_i = 8'h55;
        @(posedge clk_i); #1; check("clr_setup_55", 8'h55);
        @(negedge clk_i); clr_i = 1'b1; d_i = 8'hAA;
        #1 check("clr_not_async", 8'h55);
        @(posedge clk_i); #1; check("clr_sync", 8'h00);

        // Preset takes precedence over the synchronous clear.
        @(negedge clk_i); set_i = 1'b1;
        @(posedge clk_i); #1; check("clr_with_set", 8'hFF);
        @(negedge clk_i); set_i = 1'b0; clr_i = 1'b0;
        @(posedge clk_i); #1; check("clr_released", 8'hAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
